demux_16_regbank_wr: RTL and testbench

- Write-side counterpart of the 16-way read select path: decodes a 4-bit address into one-hot write enables and updates one of 16 WIDTH-bit entries.
- Accepts writes through a valid/ready handshake.
- Provides a sequenced 16-cycle bulk-clear walk.
- Exposes all entries flattened, so the existing 16:1 read muxes can select from them per bit.
- Used as the register-bank write port in the MIPS datapath.

---
 rtl/demux_16_regbank_wr.sv | 71 +++++++
 tb/tb_demux_16_regbank_wr.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/demux_16_regbank_wr.sv
// 16-entry register bank write port: one-hot decoded handshake writes,
// a sequenced 16-cycle clear walk, and all entries exposed flattened.
module demux_16_regbank_wr #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] CLR_VAL  = '0,
  parameter bit               ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [15:0]           we_onehot,
  output logic [16*WIDTH-1:0]   q_flat
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] mem [16];

  assign wr_ready = (state == IDLE) && !clr_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 16; k++) mem[k] <= CLR_VAL;
      state     <= IDLE;
      cnt       <= '0;
      we_onehot <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_onehot <= '0;
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (wr_valid) begin
            // Writes to a hard-wired entry 0 complete the handshake but leave no trace.
            if (!(ZERO_REG && (wr_addr == 4'd0))) begin
              mem[wr_addr] <= wr_data;
              we_onehot    <= 16'd1 << wr_addr;
            end
          end
        end
        CLEAR: begin
          mem[cnt]  <= CLR_VAL;
          we_onehot <= 16'd1 << cnt;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    q_flat = '0;
    for (int unsigned k = 0; k < 16; k++) q_flat[k*WIDTH +: WIDTH] = mem[k];
  end

endmodule

// File: tb/tb_demux_16_regbank_wr.sv
// Directed, table-driven bench for demux_16_regbank_wr (default parameters).
module tb_demux_16_regbank_wr;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          clr_req;
  logic          busy;
  logic [15:0]   we_onehot;
  logic [511:0]  q_flat;

  demux_16_regbank_wr #(.WIDTH(32), .CLR_VAL(32'h0), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy),
    .we_onehot(we_onehot), .q_flat(q_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_we;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_mem [16];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s entry%0d", tag, k), q_flat[k*32 +: 32], exp_mem[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cycles;
    vec_t v;

    // Stimulus table: single write, idle, sweep 1..15, write to hard-wired 0, idle.
    vecs.push_back('{1'b1, 4'd5, 32'hDEADBEEF, 16'h0020});
    vecs.push_back('{1'b0, 4'd5, 32'h0,        16'h0000});
    for (int a = 1; a < 16; a++)
      vecs.push_back('{1'b1, 4'(a), 32'h11111111 * a, 16'(1 << a)});
    vecs.push_back('{1'b1, 4'd0, 32'hFFFFFFFF, 16'h0000});
    vecs.push_back('{1'b0, 4'd0, 32'h0,        16'h0000});

    for (int k = 0; k < 16; k++) exp_mem[k] = 32'h0;

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset we_onehot", 32'(we_onehot), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset wr_ready", 32'(wr_ready), 32'h1);
    chk_all("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wr_valid = v.valid; wr_addr = v.addr; wr_data = v.data;
      #1 chk($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'h1);
      @(negedge clk);
      if (v.valid && v.addr != 4'd0) exp_mem[v.addr] = v.data;
      chk($sformatf("vec%0d we_onehot", i), 32'(we_onehot), 32'(v.exp_we));
      chk_all($sformatf("vec%0d", i));
    end

    // Clear request collides with a write; the write must wait out the walk.
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h1234;
    #1 chk("collide wr_ready", 32'(wr_ready), 32'h0);
    @(negedge clk);
    chk("walk start busy", 32'(busy), 32'h1);
    chk("walk start we", 32'(we_onehot), 32'h0);
    chk("walk start entry3", q_flat[3*32 +: 32], 32'h33333333);
    clr_req = 1'b0;
    busy_cycles = 1;
    for (int k = 1; k <= 16; k++) begin
      #1 if (k < 16) chk($sformatf("walk%0d wr_ready", k), 32'(wr_ready), 32'h0);
      @(negedge clk);
      exp_mem[k-1] = 32'h0;
      chk($sformatf("walk%0d we", k), 32'(we_onehot), 32'h1 << (k-1));
      if (busy) busy_cycles++;
    end
    chk("walk busy cycles", 32'(busy_cycles), 32'd16);
    chk("walk end busy", 32'(busy), 32'h0);
    chk_all("walk end");
    @(negedge clk);
    exp_mem[3] = 32'h1234;
    chk("held write we", 32'(we_onehot), 32'h0008);
    chk_all("held write");
    wr_valid = 1'b0;

    // Reset part-way through a walk.
    wr_valid = 1'b1; wr_addr = 4'd10; wr_data = 32'hCAFE000A;
    @(negedge clk);
    wr_addr = 4'd12; wr_data = 32'hCAFE000C;
    @(negedge clk);
    wr_valid = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (7) @(negedge clk);
    chk("midwalk busy", 32'(busy), 32'h1);
    chk("midwalk entry12", q_flat[12*32 +: 32], 32'hCAFE000C);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) exp_mem[k] = 32'h0;
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset we", 32'(we_onehot), 32'h0);
    chk_all("midreset");
    rst_n = 1'b1;
    #1 chk("midreset wr_ready", 32'(wr_ready), 32'h1);
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 32'hA5A50009;
    @(negedge clk);
    wr_valid = 1'b0;
    exp_mem[9] = 32'hA5A50009;
    chk("post-reset we", 32'(we_onehot), 32'h0200);
    chk_all("post-reset");
    @(negedge clk);
    chk("post-reset we idle", 32'(we_onehot), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
